// File: rtl/sum_seq_ctrl.sv
// sum_seq_ctrl: wide add/sub sequenced one SIZE_DATA-bit slice per cycle through a single SUM_unit
module SUM_unit #(
    parameter int SIZE_DATA = 28
) (
    input  logic [SIZE_DATA-1:0] i_data_a,
    input  logic [SIZE_DATA-1:0] i_data_b,
    input  logic                 i_carry,
    output logic [SIZE_DATA-1:0] o_sum,
    output logic                 o_carry
);
    assign {o_carry, o_sum} = (SIZE_DATA+1)'(i_data_a) + (SIZE_DATA+1)'(i_data_b) + (SIZE_DATA+1)'(i_carry);
endmodule

module sum_seq_ctrl #(
    parameter int SIZE_DATA = 28,
    parameter int NUM_WORDS = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_start,
    input  logic                           i_sub,
    input  logic                           i_carry,
    input  logic [NUM_WORDS*SIZE_DATA-1:0] i_data_a,
    input  logic [NUM_WORDS*SIZE_DATA-1:0] i_data_b,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [NUM_WORDS*SIZE_DATA-1:0] o_sum,
    output logic                           o_carry
);
    localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef logic [NUM_WORDS-1:0][SIZE_DATA-1:0] word_t;
    state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    word_t a_q, a_d, b_q, b_d, work_q, work_d, sum_q, sum_d;
    logic c_q, c_d, carry_q, carry_d;
    logic [SIZE_DATA-1:0] s_sum;
    logic s_carry, last;
    assign last = idx_q == IW'(NUM_WORDS-1);
    SUM_unit #(.SIZE_DATA(SIZE_DATA)) u_sum (
        .i_data_a(a_q[idx_q]),
        .i_data_b(b_q[idx_q]),
        .i_carry (c_q),
        .o_sum   (s_sum),
        .o_carry (s_carry)
    );
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) state_d = i_start ? RUN : IDLE;
        else if (state_q == RUN) state_d = last ? DONE : RUN;
        else state_d = IDLE;
    end
    always_comb begin
        o_busy = state_q != IDLE;
        o_done = state_q == DONE;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            work_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end
    // the result register loads only on the last slice so o_sum never shows a partial update
    always_comb begin
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        work_d  = work_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        if (state_q == IDLE && i_start) begin
            a_d   = i_data_a;
            b_d   = i_sub ? ~i_data_b : i_data_b;
            c_d   = i_sub | i_carry;
            idx_d = '0;
        end else if (state_q == RUN) begin
            work_d[idx_q] = s_sum;
            c_d           = s_carry;
            idx_d         = last ? '0 : idx_q + IW'(1);
            sum_d         = last ? work_d : sum_q;
            carry_d       = last ? s_carry : carry_q;
        end
    end
    assign o_sum   = sum_q;
    assign o_carry = carry_q;
endmodule
